// File: rtl/taillight_input_cond_pkg.sv
// Shared constants for the tail-light input conditioning stage.
// Sets the default timing parameters and the channel ordering.
package taillight_pkg;

   localparam int DEBOUNCE_DEFAULT = 500000;
   localparam int STEP_DEFAULT     = 12500000;

   localparam int NUM_CH   = 3;
   localparam int CH_LEFT  = 0;
   localparam int CH_RIGHT = 1;
   localparam int CH_HAZ   = 2;

   typedef logic [NUM_CH-1:0] ch_vec_t;

   function automatic ch_vec_t pack_ch(input logic left, input logic right, input logic haz);
      ch_vec_t v;
      v           = '0;
      v[CH_LEFT]  = left;
      v[CH_RIGHT] = right;
      v[CH_HAZ]   = haz;
      return v;
   endfunction

endpackage

// File: rtl/taillight_input_cond_if.sv
// Switch-side and sequencer-side signals of the input conditioning stage.
// The master drives the raw switches; the slave (the conditioner) drives the levels and STEP.
interface taillight_input_cond_if;
   import taillight_pkg::*;

   logic LEFT_RAW;
   logic RIGHT_RAW;
   logic HAZ_RAW;
   logic LEFT;
   logic RIGHT;
   logic HAZ;
   logic STEP;

   modport master (
      output LEFT_RAW, RIGHT_RAW, HAZ_RAW,
      input  LEFT, RIGHT, HAZ, STEP
   );

   modport slave (
      input  LEFT_RAW, RIGHT_RAW, HAZ_RAW,
      output LEFT, RIGHT, HAZ, STEP
   );

endinterface

// File: rtl/taillight_input_cond_debounce_channel.sv
// One switch channel: two-flop synchronizer, debouncer, pending-press latch and
// the output register that loads on the edge that asserts STEP.
module debounce_channel
   import taillight_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
   input  logic CLOCK,
   input  logic RESET,
   input  logic i_raw,
   input  logic i_step_load,
   output logic o_level
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic          r_sync1;
   logic          r_sync2;
   logic          r_deb;
   logic          r_pend;
   logic          r_level;
   logic [CW-1:0] r_cnt;

   logic w_diff;
   logic w_toggle;
   logic w_rise;

   assign w_diff   = (r_sync2 != r_deb);
   assign w_toggle = w_diff && (r_cnt == CNT_MAX);
   assign w_rise   = w_toggle && !r_deb;

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_deb   <= 1'b0;
         r_cnt   <= '0;
         r_pend  <= 1'b0;
         r_level <= 1'b0;
      end else begin
         r_sync1 <= i_raw;
         r_sync2 <= r_sync1;

         if (!w_diff || w_toggle) r_cnt <= '0;
         else                     r_cnt <= r_cnt + 1'b1;

         if (w_toggle) r_deb <= ~r_deb;

         // A rise landing on the step edge must survive into the next step.
         if (w_rise)           r_pend <= 1'b1;
         else if (i_step_load) r_pend <= 1'b0;

         if (i_step_load) r_level <= r_deb | r_pend;
      end
   end

   assign o_level = r_level;

endmodule

// File: rtl/taillight_input_cond.sv
// Input conditioning for the tail-light sequencer: shared STEP generator plus
// one debounce channel per switch (left, right, hazard).
module taillight_input_cond
   import taillight_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
   parameter int STEP_CYCLES     = STEP_DEFAULT
) (
   input logic                   CLOCK,
   input logic                   RESET,
   taillight_input_cond_if.slave bus
);

   localparam int SW = $clog2(STEP_CYCLES);
   localparam logic [SW-1:0] SCNT_MAX = SW'(STEP_CYCLES - 1);

   logic [SW-1:0] r_scnt;
   logic          r_step;
   logic          w_wrap;
   ch_vec_t       w_raw;
   ch_vec_t       w_level;

   // w_wrap marks the edge that asserts STEP; channels load on that same edge.
   assign w_wrap = (r_scnt == SCNT_MAX);

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         r_scnt <= '0;
         r_step <= 1'b0;
      end else begin
         r_scnt <= w_wrap ? '0 : r_scnt + 1'b1;
         r_step <= w_wrap;
      end
   end

   assign w_raw = pack_ch(bus.LEFT_RAW, bus.RIGHT_RAW, bus.HAZ_RAW);

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      debounce_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_ch (
         .CLOCK       (CLOCK),
         .RESET       (RESET),
         .i_raw       (w_raw[g]),
         .i_step_load (w_wrap),
         .o_level     (w_level[g])
      );
   end

   assign bus.LEFT  = w_level[CH_LEFT];
   assign bus.RIGHT = w_level[CH_RIGHT];
   assign bus.HAZ   = w_level[CH_HAZ];
   assign bus.STEP  = r_step;

endmodule

// File: tb/tb_taillight_input_cond.sv
// Bench for taillight_input_cond with DEBOUNCE_CYCLES=4, STEP_CYCLES=16.
// Edges are numbered from the first edge after RESET release; drives happen just after an edge.
module tb_taillight_input_cond;
   import taillight_pkg::*;

   localparam int DEB = 4;
   localparam int STP = 16;
   localparam int LAST_EDGE = 170;

   logic CLOCK = 1'b0;
   logic RESET;

   taillight_input_cond_if bus ();

   taillight_input_cond #(
      .DEBOUNCE_CYCLES (DEB),
      .STEP_CYCLES     (STP)
   ) dut (
      .CLOCK (CLOCK),
      .RESET (RESET),
      .bus   (bus)
   );

   always #5 CLOCK = ~CLOCK;

   typedef struct {
      int   edge_n;
      logic rst;
      logic l;
      logic r;
      logic h;
   } drv_t;

   typedef struct {
      int         edge_n;
      logic [3:0] exp_lrhs;
      string      name;
   } chk_t;

   drv_t drv[$];
   chk_t chk[$];

   int n_err = 0;
   int n_chk = 0;

   task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got LRHS=%b, required %b", name, got, exp);
      end
   endtask

   function automatic logic [3:0] outs();
      return {bus.LEFT, bus.RIGHT, bus.HAZ, bus.STEP};
   endfunction

   initial begin
      int di;
      int ci;
      logic exp_step;

      // After edge N, apply {RESET, LEFT_RAW, RIGHT_RAW, HAZ_RAW}.
      drv.push_back('{16,  1'b0, 1'b1, 1'b0, 1'b0});  // clean left press
      drv.push_back('{32,  1'b0, 1'b1, 1'b1, 1'b0});  // right bounces every 2 cycles
      drv.push_back('{34,  1'b0, 1'b1, 1'b0, 1'b0});
      drv.push_back('{36,  1'b0, 1'b1, 1'b1, 1'b0});
      drv.push_back('{38,  1'b0, 1'b1, 1'b0, 1'b0});
      drv.push_back('{40,  1'b0, 1'b1, 1'b1, 1'b0});
      drv.push_back('{42,  1'b0, 1'b1, 1'b0, 1'b0});
      drv.push_back('{44,  1'b0, 1'b1, 1'b1, 1'b0});
      drv.push_back('{46,  1'b0, 1'b1, 1'b0, 1'b0});
      drv.push_back('{48,  1'b0, 1'b1, 1'b1, 1'b0});
      drv.push_back('{50,  1'b0, 1'b1, 1'b0, 1'b0});
      drv.push_back('{64,  1'b0, 1'b1, 1'b0, 1'b1});  // 8-cycle hazard press between steps
      drv.push_back('{72,  1'b0, 1'b1, 1'b0, 1'b0});
      drv.push_back('{106, 1'b0, 1'b1, 1'b1, 1'b0});  // right deb rises exactly on edge 112
      drv.push_back('{114, 1'b0, 1'b1, 1'b0, 1'b0});  // and falls at 120, before the next step
      drv.push_back('{146, 1'b0, 1'b1, 1'b0, 1'b1});  // hazard count in flight
      drv.push_back('{150, 1'b1, 1'b1, 1'b0, 1'b1});  // reset hits edges 151,152
      drv.push_back('{152, 1'b0, 1'b1, 1'b0, 1'b1});

      // After edge N, expect {LEFT, RIGHT, HAZ, STEP}.
      chk.push_back('{8,   4'b0000, "idle"});
      chk.push_back('{15,  4'b0000, "pre_first_step"});
      chk.push_back('{16,  4'b0001, "first_step"});
      chk.push_back('{31,  4'b0000, "left_before_load"});
      chk.push_back('{32,  4'b1001, "left_load"});
      chk.push_back('{40,  4'b1000, "bounce_mid"});
      chk.push_back('{48,  4'b1001, "bounce_step"});
      chk.push_back('{52,  4'b1000, "bounce_settled"});
      chk.push_back('{64,  4'b1001, "step_before_haz"});
      chk.push_back('{79,  4'b1000, "haz_before_load"});
      chk.push_back('{80,  4'b1011, "haz_captured"});
      chk.push_back('{95,  4'b1010, "haz_held"});
      chk.push_back('{96,  4'b1001, "haz_released"});
      chk.push_back('{111, 4'b1000, "coin_before"});
      chk.push_back('{112, 4'b1001, "coin_old_value"});
      chk.push_back('{127, 4'b1000, "coin_held_old"});
      chk.push_back('{128, 4'b1101, "coin_pend_load"});
      chk.push_back('{143, 4'b1100, "coin_hold"});
      chk.push_back('{144, 4'b1001, "coin_clear"});
      chk.push_back('{150, 4'b1000, "pre_reset"});
      chk.push_back('{151, 4'b0000, "reset_edge"});
      chk.push_back('{152, 4'b0000, "reset_hold"});
      chk.push_back('{167, 4'b0000, "restart_pre_step"});
      chk.push_back('{168, 4'b1011, "restart_step"});

      RESET         = 1'b1;
      bus.LEFT_RAW  = 1'b0;
      bus.RIGHT_RAW = 1'b0;
      bus.HAZ_RAW   = 1'b0;

      for (int k = 0; k < 3; k++) begin
         @(posedge CLOCK);
         @(negedge CLOCK);
         check($sformatf("reset_cycle%0d", k), outs(), 4'b0000);
      end
      RESET = 1'b0;

      di = 0;
      ci = 0;
      for (int n = 1; n <= LAST_EDGE; n++) begin
         @(posedge CLOCK);
         #1;
         while (di < drv.size() && drv[di].edge_n == n) begin
            RESET         = drv[di].rst;
            bus.LEFT_RAW  = drv[di].l;
            bus.RIGHT_RAW = drv[di].r;
            bus.HAZ_RAW   = drv[di].h;
            di++;
         end
         @(negedge CLOCK);

         if (n == 151 || n == 152) exp_step = 1'b0;
         else if (n < 151)         exp_step = ((n % STP) == 0);
         else                      exp_step = (((n - 152) % STP) == 0);
         check($sformatf("step_period@%0d", n), {3'b000, bus.STEP}, {3'b000, exp_step});

         if (n >= 33 && n <= 105)
            check($sformatf("right_bounce@%0d", n), {3'b000, bus.RIGHT}, 4'b0000);

         while (ci < chk.size() && chk[ci].edge_n == n) begin
            check($sformatf("%s@%0d", chk[ci].name, n), outs(), chk[ci].exp_lrhs);
            ci++;
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/taillight_input_cond.md
# taillight_input_cond

Input conditioning stage for the tail-light sequencer. Takes the three raw driver switches (left turn, right turn, hazard) and synchronizes and debounces each one. Presents them to the sequencer as stable levels, updated only on a slow STEP pulse, which is also the sequencer's advance enable. Short presses that occur between steps are captured so no request is lost.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 500000: consecutive stable cycles required to accept a switch change (10 ms at 50 MHz); legal minimum 2.
- STEP_CYCLES, default 12500000: period of STEP in CLOCK cycles (4 Hz at 50 MHz); legal minimum 2.

Ports:
- CLOCK  in  1  system clock; all state is updated on its rising edge.
- RESET  in  1  reset: RESET, synchronous, active-high; clock CLOCK.
- LEFT_RAW  in  1  left switch, asynchronous, may bounce.
- RIGHT_RAW  in  1  right switch, asynchronous, may bounce.
- HAZ_RAW  in  1  hazard switch, asynchronous, may bounce.
- LEFT  out  1  conditioned left request; changes only on STEP edges.
- RIGHT  out  1  conditioned right request; changes only on STEP edges.
- HAZ  out  1  conditioned hazard request; changes only on STEP edges.
- STEP  out  1  one-cycle advance pulse for the sequencer.

## Operation
Each channel has its own pipeline of synchronizer, debouncer and pending latch. The three channels are identical and independent.

- **Synchronizer:** two flops, sync1 then sync2.
- **Debouncer:** holds the accepted level `deb` and a counter `cnt` of width $clog2(DEBOUNCE_CYCLES).
  - If sync2 == deb, cnt is cleared to 0.
  - If sync2 != deb and cnt == DEBOUNCE_CYCLES-1, deb toggles and cnt is cleared to 0.
  - Otherwise cnt increments. Any single-cycle return to the old level restarts the count.
- **Pending latch:** `pend` is set on the cycle deb rises (0→1). It is cleared on a STEP edge, unless deb rises on that same edge, in which case it stays set.
- **Output load:** on the edge that asserts STEP, output <= deb | pend. A press longer than the debounce time but shorter than the step period therefore appears as a 1 for exactly one step.
- **Step generator:** counter `scnt` of width $clog2(STEP_CYCLES), counting 0..STEP_CYCLES-1 and wrapping. STEP is registered and is 1 exactly when scnt wraps to 0. STEP outputs are exactly STEP_CYCLES cycles apart.
- No arbitration between channels. LEFT=RIGHT=1 and HAZ combined with others pass through unchanged; the sequencer resolves priority.

## Timing
- **Reset values:** every output is 0. sync1, sync2, deb, pend, cnt and scnt are all 0.
- **RESET mid-operation:** takes effect at the next edge; all in-flight counts and pending presses are discarded.
- **First STEP:** the first STEP pulse is high in the cycle following the STEP_CYCLES-th edge after RESET deasserts.
- **Raw to deb:** a clean raw edge reaches sync2 after 2 edges. deb toggles DEBOUNCE_CYCLES edges after that, so 2+DEBOUNCE_CYCLES edges in total.
- **deb to output:** latency runs from the deb change to the next STEP edge, so between 1 and STEP_CYCLES cycles.
- **Output validity:** outputs are valid during the STEP-high cycle and are held constant until the next STEP edge.
- **Simultaneous events:** if deb changes on the same edge as STEP, the load uses the pre-edge deb. A rise on that edge is kept in pend for the following step.

## Structure
- Shared package `taillight_pkg` holds:
  - the default parameter constants DEBOUNCE_DEFAULT and STEP_DEFAULT;
  - channel index constants CH_LEFT=0, CH_RIGHT=1, CH_HAZ=2;
  - NUM_CH=3.
- Sub-module `debounce_channel` contains the synchronizer, debouncer and pending latch. It takes the step input and produces the registered output bit. The top level instantiates it NUM_CH times alongside the shared step generator. Expected size is about 150 lines of RTL.

## Test plan
The bench uses DEBOUNCE_CYCLES=4 and STEP_CYCLES=16.
- **Reset and step:** hold RESET 3 cycles, then release with all raw inputs 0. Required: all outputs 0 throughout; STEP high exactly one cycle in every 16, first one 16 edges after release.
- **Clean press:** LEFT_RAW goes 0→1 and is held. Required: deb rises 6 edges later; LEFT=1 from the next STEP; RIGHT and HAZ stay 0.
- **Bounce rejection:** RIGHT_RAW toggles every 2 cycles for 20 cycles, then settles at 0. Required: RIGHT never leaves 0; deb never toggles.
- **Short press capture:** HAZ_RAW is held 1 for 8 cycles entirely between two STEPs, then returns to 0. Required: HAZ=1 for exactly one step period, then 0.
- **Coincident rise:** a deb rise is forced on the STEP edge. Required: output stays at the old value for that step and goes to 1 at the following STEP.
- **Mid-operation reset:** assert RESET while LEFT=1 and with cnt and scnt nonzero. Required: all outputs go to 0 at the next edge, and the next STEP occurs 16 edges after release.
